lvt_multi_port_ram: RTL and testbench
=====================================

// Module: lvt_multi_port_ram
// PURPOSE
// - Parametrised N_WRITE x N_READ block RAM built from 1W1R banks plus a live value table (LVT).
// - Successor to the fixed 2W2R RAM: generic port counts, defined same-address write priority,
//   selectable read-during-write mode, and a post-reset clear sequencer with a ready flag.
// - Sits beside packet/lookup logic that needs several independent single-cycle accesses per clock.
// PARAMETERS
// - DATA_W          32  data width per port
// - ADDR_W          8   address width; DEPTH = 2**ADDR_W
// - N_READ          2   read ports (>=1)
// - N_WRITE         2   write ports (>=1); LVT_W = max(1, clog2(N_WRITE))
// - BYPASS          0   0: read-old on same-address read/write; 1: forward the new write data
// - CLEAR_ON_RESET  1   1: zero every location after reset before asserting ready
// PORTS
// - clk    in   1               clock, all logic on posedge
// - rst    in   1               asynchronous, active-high reset
// - ready  out  1               high once RAM accepts writes and returns valid reads
// - raddr  in   N_READ*ADDR_W   read address, port r at [r*ADDR_W +: ADDR_W]
// - rdata  out  N_READ*DATA_W   read data, port r at [r*DATA_W +: DATA_W]
// - wen    in   N_WRITE         write enable per write port
// - waddr  in   N_WRITE*ADDR_W  write address per write port
// - wdata  in   N_WRITE*DATA_W  write data per write port
// BEHAVIOUR
// - Reset: ready=0, rdata=0, FSM=CLEAR (or RUN path below if CLEAR_ON_RESET=0). Arrays are not reset.
// - FSM CLEAR: clr_addr counts 0..DEPTH-1, one per cycle; writes 0 to bank[0][*] and LVT=0 at clr_addr.
//   At clr_addr==DEPTH-1 -> RUN next cycle; ready rises the cycle after the last clear write.
//   User writes ignored in CLEAR; rdata held at 0. rst mid-clear restarts from address 0.
// - CLEAR_ON_RESET=0: FSM goes straight to RUN; ready=1 the first clk edge after rst falls;
//   unwritten locations return undefined data.
// - Write (RUN): port w with wen[w] writes wdata[w] into bank[w][r] for every r, and sets LVT[waddr]=w.
// - Same-address writes in one cycle: lowest-index enabled port wins; higher ports to that address
//   are suppressed (no bank write, no LVT update). No assumption on callers is required.
// - Read latency 1: rdata[r] at edge N+1 = location raddr[r] as of edge N.
//   LVT and bank[*][r] sampled at the same edge; mux bank[LVT][r] after the registers.
// - Read-during-write same address, same cycle: BYPASS=0 -> old value; BYPASS=1 -> winning write's
//   data (forward mux registered alongside). Reads of other addresses unaffected.
// - Write-then-read next cycle always returns the new value in both modes.
// - rdata is a registered output, async-reset to 0; holds last value only via re-read (no enable).
// - All addresses wrap naturally at ADDR_W; no out-of-range case exists.
// STRUCTURE
// - Package lvt_ram_pkg: state_t enum {ST_CLEAR, ST_RUN}; function clog2; LVT_W computation.
// - Sub-module sdp_ram_bank (1W1R, DATA_W x DEPTH, registered read, no reset on array);
//   instantiated N_WRITE*N_READ times via generate. LVT is a DEPTH x LVT_W register array
//   with N_WRITE write / N_READ read ports, in this module. Priority/suppression logic and FSM here.
// TESTING
// - Formal harness: anyconst f_addr; shadow register tracks priority-winning writes to f_addr
//   (0 after clear); assert rdata[r]==shadow one cycle after raddr[r]==f_addr, ready high,
//   for N_READ=3, N_WRITE=3, both BYPASS values; no assume on write collisions.
// - Reset/clear: DATA_W=8, ADDR_W=4, release rst -> ready=0 for 16 cycles then 1; read all 16 -> 0x00.
// - Priority: wen=3'b111, all waddr=5, wdata={0x33,0x22,0x11} -> next-cycle read of 5 = 0x11.
// - RDW: LOC 7=0xAA; write 7<=0xBB while reading 7 -> BYPASS=0 gives 0xAA, BYPASS=1 gives 0xBB;
//   read again next cycle -> 0xBB both modes.
// - Cross-port: port1 writes 9<=0x5A, port0 writes 9<=0xC3 next cycle -> all read ports see 0xC3.
// - Reset mid-clear: assert rst at clr_addr=6 for 1 cycle -> rdata=0, ready=0, clear restarts,
//   ready rises exactly DEPTH+1 cycles after rst falls; writes during CLEAR leave contents 0.

Source files
------------

// File: rtl/lvt_ram_pkg.sv
// lvt_ram_pkg
// Shared types and helpers for the live-value-table multi-port RAM.
//   state_t   : sequencer states (clear after reset, normal run)
//   clog2     : ceiling log2 of a positive integer
//   lvt_width : bits needed per LVT entry to name one write port (at least 1)
package lvt_ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int lvt_width(input int n_write);
        int w;
        w = clog2(n_write);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sdp_ram_bank.sv
// sdp_ram_bank
// Simple dual-port bank: one write port, one read port, registered read,
// array not reset. A read of an address written on the same edge returns
// the old contents.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, one cycle after raddr_i
module sdp_ram_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lvt_multi_port_ram.sv
// lvt_multi_port_ram
// N_WRITE x N_READ RAM built from N_WRITE*N_READ 1W1R banks plus a live
// value table recording which write port last wrote each address. After
// reset an optional sequencer zeroes every location before raising ready.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   ready  : RAM accepts writes and returns valid reads
//   raddr  : read addresses, port r at [r*ADDR_W +: ADDR_W]
//   rdata  : read data (1-cycle latency), port r at [r*DATA_W +: DATA_W]
//   wen    : write enable per write port
//   waddr  : write addresses, port w at [w*ADDR_W +: ADDR_W]
//   wdata  : write data, port w at [w*DATA_W +: DATA_W]
//
// state    | meaning
// ST_CLEAR | zero bank[0][*] and LVT at clr_addr, user writes ignored
// ST_RUN   | normal operation
module lvt_multi_port_ram
    import lvt_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int N_READ         = 2,
    parameter int N_WRITE        = 2,
    parameter int BYPASS         = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        ready,
    input  logic [N_READ*ADDR_W-1:0]    raddr,
    output logic [N_READ*DATA_W-1:0]    rdata,
    input  logic [N_WRITE-1:0]          wen,
    input  logic [N_WRITE*ADDR_W-1:0]   waddr,
    input  logic [N_WRITE*DATA_W-1:0]   wdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LVT_W = lvt_width(N_WRITE);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              ready_q;

    logic              clearing;
    logic              running;
    logic [N_WRITE-1:0] win_wen;

    logic [ADDR_W-1:0] waddr_w [N_WRITE];
    logic [DATA_W-1:0] wdata_w [N_WRITE];
    logic [ADDR_W-1:0] raddr_r [N_READ];

    logic [DATA_W-1:0] bank_rd [N_WRITE][N_READ];
    logic [LVT_W-1:0]  lvt_mem [DEPTH];
    logic [LVT_W-1:0]  lvt_rd_q [N_READ];
    logic [DATA_W-1:0] rd_word [N_READ];

    for (genvar w = 0; w < N_WRITE; w++) begin : g_wunpack
        assign waddr_w[w] = waddr[w*ADDR_W +: ADDR_W];
        assign wdata_w[w] = wdata[w*DATA_W +: DATA_W];
    end

    for (genvar r = 0; r < N_READ; r++) begin : g_runpack
        assign raddr_r[r] = raddr[r*ADDR_W +: ADDR_W];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            // ready trails the RUN state by one edge, so it rises the cycle
            // after the last clear write
            ready_q    <= (state_q == ST_RUN);
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                clr_addr_d = '0;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Output / write-qualification logic
    always_comb begin
        clearing = (state_q == ST_CLEAR);
        running  = (state_q == ST_RUN);
        for (int w = 0; w < N_WRITE; w++) begin
            win_wen[w] = wen[w] & running;
            // a lower-indexed enabled port to the same address takes priority
            for (int j = 0; j < N_WRITE; j++) begin
                if ((j < w) && wen[j] && (waddr_w[j] == waddr_w[w])) begin
                    win_wen[w] = 1'b0;
                end
            end
        end
    end

    // Bank grid: bank[w][r] holds port w's writes, read by read port r.
    // Clearing only needs bank 0 because the LVT is zeroed alongside it.
    for (genvar w = 0; w < N_WRITE; w++) begin : g_wr
        logic              bank_we;
        logic [ADDR_W-1:0] bank_waddr;
        logic [DATA_W-1:0] bank_wdata;

        assign bank_we    = win_wen[w] | (clearing & (w == 0));
        assign bank_waddr = clearing ? clr_addr_q : waddr_w[w];
        assign bank_wdata = clearing ? '0 : wdata_w[w];

        for (genvar r = 0; r < N_READ; r++) begin : g_rd
            sdp_ram_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk_i   (clk),
                .we_i    (bank_we),
                .waddr_i (bank_waddr),
                .wdata_i (bank_wdata),
                .raddr_i (raddr_r[r]),
                .rdata_o (bank_rd[w][r])
            );
        end
    end

    // Live value table; winners never share an address, so the port
    // writes below never collide
    always_ff @(posedge clk) begin
        if (clearing) begin
            lvt_mem[clr_addr_q] <= '0;
        end
        for (int w = 0; w < N_WRITE; w++) begin
            if (win_wen[w]) begin
                lvt_mem[waddr_w[w]] <= LVT_W'(w);
            end
        end
        for (int r = 0; r < N_READ; r++) begin
            lvt_rd_q[r] <= lvt_mem[raddr_r[r]];
        end
    end

    for (genvar r = 0; r < N_READ; r++) begin : g_rmux
        logic [DATA_W-1:0] bank_sel;

        always_comb begin
            bank_sel = '0;
            for (int w = 0; w < N_WRITE; w++) begin
                if (lvt_rd_q[r] == LVT_W'(w)) begin
                    bank_sel = bank_rd[w][r];
                end
            end
        end

        if (BYPASS != 0) begin : g_fwd
            logic              fwd_hit_d, fwd_hit_q;
            logic [DATA_W-1:0] fwd_data_d, fwd_data_q;

            always_comb begin
                fwd_hit_d  = 1'b0;
                fwd_data_d = '0;
                for (int w = 0; w < N_WRITE; w++) begin
                    if (win_wen[w] && (waddr_w[w] == raddr_r[r])) begin
                        fwd_hit_d  = 1'b1;
                        fwd_data_d = wdata_w[w];
                    end
                end
            end

            always_ff @(posedge clk) begin
                fwd_hit_q  <= fwd_hit_d;
                fwd_data_q <= fwd_data_d;
            end

            assign rd_word[r] = fwd_hit_q ? fwd_data_q : bank_sel;
        end else begin : g_nofwd
            assign rd_word[r] = bank_sel;
        end

        // ready_q is reset asynchronously, which forces rdata to zero
        // during reset and throughout the clear sequence
        assign rdata[r*DATA_W +: DATA_W] = ready_q ? rd_word[r] : '0;
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_lvt_multi_port_ram.sv
module tb_lvt_multi_port_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int NW    = 3;
    localparam int DEPTH = 16;

    logic              clk;
    logic              rst;
    logic              ready0, ready1;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata0, rdata1;
    logic [NW-1:0]     wen;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;

    typedef struct {
        string    tag;
        int       port;
        logic [7:0] e0;
        logic [7:0] e1;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem[DEPTH];
    int         total;
    int         bad;

    lvt_multi_port_ram #(
        .DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW),
        .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .ready(ready0), .raddr(raddr), .rdata(rdata0),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    lvt_multi_port_ram #(
        .DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW),
        .BYPASS(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .ready(ready1), .raddr(raddr), .rdata(rdata1),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_io(input logic [2:0] we,
                          input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [3:0] r0, input logic [3:0] r1);
        wen   = we;
        waddr = {a2, a1, a0};
        wdata = {d2, d1, d0};
        raddr = {r1, r0};
    endtask

    // One clock of RUN-mode traffic: expectations pushed from the model
    // before the edge, popped and compared after it.
    task automatic step(input string tag);
        exp_t e;
        for (int r = 0; r < NR; r++) begin
            logic [3:0] ra;
            ra     = raddr[r*AW +: AW];
            e.tag  = tag;
            e.port = r;
            e.e0   = mem[ra];
            e.e1   = mem[ra];
            // walking down from the top port leaves the lowest enabled port
            for (int w = NW - 1; w >= 0; w--) begin
                if (wen[w] && (waddr[w*AW +: AW] == ra)) e.e1 = wdata[w*DW +: DW];
            end
            sb.push_back(e);
        end
        for (int w = NW - 1; w >= 0; w--) begin
            if (wen[w]) mem[waddr[w*AW +: AW]] = wdata[w*DW +: DW];
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check8({e.tag, "_bp0"}, rdata0[e.port*DW +: DW], e.e0);
            check8({e.tag, "_bp1"}, rdata1[e.port*DW +: DW], e.e1);
        end
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a += 2) begin
            set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'(a), 4'(a + 1));
            step(tag);
        end
    endtask

    initial begin
        int n0, n1;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check_int("rst_ready0", int'(ready0), 0);
        check_int("rst_ready1", int'(ready1), 0);
        check8("rst_rdata0", rdata0[7:0], 8'h00);
        check8("rst_rdata1", rdata1[15:8], 8'h00);

        // plain clear: ready low for DEPTH edges, high on edge DEPTH+1
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check_int("clr_ready_lo", int'(ready0 | ready1), 0);
            check8("clr_rdata_lo", rdata0[7:0] | rdata1[7:0], 8'h00);
        end
        @(posedge clk);
        #1;
        check_int("clr_ready_hi0", int'(ready0), 1);
        check_int("clr_ready_hi1", int'(ready1), 1);
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
        read_all("clr_read");

        // same-address write priority
        set_io(3'b111, 4'd5, 4'd5, 4'd5, 8'h11, 8'h22, 8'h33, 4'd0, 4'd1);
        step("prio_wr");
        set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd5, 4'd5);
        step("prio_rd");
        check8("prio_const0", rdata0[7:0], 8'h11);
        check8("prio_const1", rdata1[15:8], 8'h11);

        // read during write
        set_io(3'b001, 4'd7, 4'd0, 4'd0, 8'hAA, 8'h00, 8'h00, 4'd0, 4'd1);
        step("rdw_init");
        set_io(3'b001, 4'd7, 4'd0, 4'd0, 8'hBB, 8'h00, 8'h00, 4'd7, 4'd3);
        step("rdw_same");
        check8("rdw_old", rdata0[7:0], 8'hAA);
        check8("rdw_fwd", rdata1[7:0], 8'hBB);
        set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd7, 4'd7);
        step("rdw_next");
        check8("rdw_next0", rdata0[15:8], 8'hBB);
        check8("rdw_next1", rdata1[7:0], 8'hBB);

        // cross-port overwrite
        set_io(3'b010, 4'd0, 4'd9, 4'd0, 8'h00, 8'h5A, 8'h00, 4'd2, 4'd4);
        step("xp_wr1");
        set_io(3'b001, 4'd9, 4'd0, 4'd0, 8'hC3, 8'h00, 8'h00, 4'd6, 4'd8);
        step("xp_wr0");
        set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd9, 4'd9);
        step("xp_rd");
        check8("xp_const0", rdata0[7:0], 8'hC3);
        check8("xp_const1", rdata1[15:8], 8'hC3);

        // random traffic, narrow address window every other step to force collisions
        for (int i = 0; i < 60; i++) begin
            int hi;
            hi = (i % 2 == 0) ? 3 : 15;
            set_io(3'($urandom_range(0, 7)),
                   4'($urandom_range(0, hi)), 4'($urandom_range(0, hi)), 4'($urandom_range(0, hi)),
                   8'($urandom), 8'($urandom), 8'($urandom),
                   4'($urandom_range(0, hi)), 4'($urandom_range(0, hi)));
            step("rand");
        end

        // give every location nonzero content before the mid-clear reset
        for (int a = 0; a < DEPTH; a++) begin
            set_io(3'b100, 4'd0, 4'd0, 4'(a), 8'h00, 8'h00, 8'(8'h80 + a), 4'(a), 4'd0);
            step("fill");
        end

        // reset in the middle of a clear
        set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd12, 4'd13);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_int("midrst_ready", int'(ready0 | ready1), 0);
        check8("midrst_rdata0", rdata0[7:0] | rdata0[15:8], 8'h00);
        check8("midrst_rdata1", rdata1[7:0] | rdata1[15:8], 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_io(3'b111, 4'd12, 4'd13, 4'd14, 8'hFF, 8'hEE, 8'hDD, 4'd12, 4'd13);
        n0 = 0;
        n1 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready0 && n0 == 0) n0 = n;
            if (ready1 && n1 == 0) n1 = n;
            if (!ready0) check8("clr2_hold0", rdata0[7:0] | rdata0[15:8], 8'h00);
            if (!ready1) check8("clr2_hold1", rdata1[7:0] | rdata1[15:8], 8'h00);
            if (n0 != 0 && n1 != 0) break;
            // keep hammering writes only across the clear edges
            if (n < DEPTH)
                set_io(3'b111, 4'($urandom), 4'($urandom), 4'($urandom),
                       8'($urandom | 1), 8'($urandom | 1), 8'($urandom | 1), 4'd12, 4'd13);
            else
                set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd12, 4'd13);
        end
        check_int("clr2_ready_edge0", n0, DEPTH + 1);
        check_int("clr2_ready_edge1", n1, DEPTH + 1);
        set_io(3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0);
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
        read_all("clr2_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
